decode_stage_control: RTL and testbench

Pipeline-stage controller between instruction fetch and the execute datapath. Accepts fetched instructions over a valid/ready handshake and buffers them in a two-entry skid buffer. Decodes each opcode into the 3-bit immediate-format select that drives the immediate generator. Illegal instructions are trapped in an FSM that holds the stage until the trap is acknowledged.

---
 rtl/decode_stage_control_pkg.sv | 38 +++
 rtl/decode_stage_control_if.sv | 29 ++
 rtl/decode_stage_control_decoder.sv | 41 ++++
 rtl/decode_stage_control.sv | 87 ++++++++
 tb/tb_decode_stage_control.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_control_pkg.sv
// Shared decode definitions: immediate-format selects, RV32 opcodes,
// stage FSM states and the buffer entry layout.
package rv_decode_pkg;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_CSR  = 3'b110;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [2:0]  select;
        logic        illegal_flag;
        logic        valid;
    } entry_t;

endpackage

// File: rtl/decode_stage_control_if.sv
// Fetch/execute/trap signal bundle of the decode stage; slave is the stage,
// master is whatever drives it (fetch, execute and trap handler together).
interface decode_stage_control_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  immediate_select;
    logic        flush;
    logic        illegal;
    logic [31:0] trap_pc;
    logic        trap_ack;

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready, flush, trap_ack,
        output in_ready, out_valid, out_instruction, out_pc, immediate_select,
        illegal, trap_pc
    );

    modport master (
        output in_valid, in_instruction, in_pc, out_ready, flush, trap_ack,
        input  in_ready, out_valid, out_instruction, out_pc, immediate_select,
        illegal, trap_pc
    );
endinterface

// File: rtl/decode_stage_control_decoder.sv
// Opcode to immediate-format decode; purely combinational, flags words
// the stage must trap on.
module imm_select_decoder
    import rv_decode_pkg::*;
#(
    parameter bit ENABLE_CSR = 1'b1
) (
    input  logic [31:0] instruction,
    output logic [2:0]  immediate_select,
    output logic        illegal
);

    logic unused_bits;
    assign unused_bits = ^{instruction[31:15], instruction[11:7]};

    always_comb begin
        immediate_select = IMM_NONE;
        illegal          = 1'b0;
        // Compressed or malformed encodings never match the full opcode table.
        if (instruction[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            unique case (instruction[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR: immediate_select = IMM_I;
                OPC_STORE:                      immediate_select = IMM_S;
                OPC_BRANCH:                     immediate_select = IMM_B;
                OPC_LUI, OPC_AUIPC:             immediate_select = IMM_U;
                OPC_JAL:                        immediate_select = IMM_J;
                OPC_OP, OPC_MISC_MEM:           immediate_select = IMM_NONE;
                OPC_SYSTEM: begin
                    if (instruction[14:12] != 3'b000) begin
                        if (ENABLE_CSR) immediate_select = IMM_CSR;
                        else            illegal          = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage_control.sv
// Decode stage controller: two-entry skid buffer between fetch and execute,
// with a RUN/TRAP FSM that parks the stage on an illegal instruction.
module decode_stage_control
    import rv_decode_pkg::*;
#(
    parameter bit ENABLE_CSR = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_stage_control_if.slave bus
);

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t incoming;
    logic [2:0] dec_select;
    logic       dec_illegal;
    logic       accept;
    logic       consume;

    imm_select_decoder #(.ENABLE_CSR(ENABLE_CSR)) u_decoder (
        .instruction      (bus.in_instruction),
        .immediate_select (dec_select),
        .illegal          (dec_illegal)
    );

    // All handshake outputs come from registered state only.
    assign bus.in_ready  = (state == ST_RUN) && !skid.valid;
    assign bus.out_valid = (state == ST_RUN) && head.valid && !head.illegal_flag;
    assign bus.illegal   = head.valid && head.illegal_flag;
    assign bus.trap_pc   = bus.illegal ? head.pc : 32'd0;

    assign bus.out_instruction  = head.valid ? head.instruction : 32'd0;
    assign bus.out_pc           = head.valid ? head.pc : 32'd0;
    assign bus.immediate_select = head.valid ? head.select : IMM_NONE;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    always_comb begin
        incoming              = '0;
        incoming.instruction  = bus.in_instruction;
        incoming.pc           = bus.in_pc;
        incoming.select       = dec_select;
        incoming.illegal_flag = dec_illegal;
        incoming.valid        = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            head  <= '0;
            skid  <= '0;
        end else if (bus.flush) begin
            state <= ST_RUN;
            head  <= '0;
            skid  <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (head.valid && head.illegal_flag) state <= ST_TRAP;
                    // Skid can only be valid when no accept is possible.
                    if (!head.valid || consume) begin
                        if (skid.valid) begin
                            head <= skid;
                            skid <= '0;
                        end else begin
                            head <= accept ? incoming : '0;
                        end
                    end else if (accept) begin
                        skid <= incoming;
                    end
                end
                ST_TRAP: begin
                    if (bus.trap_ack) begin
                        state <= ST_RUN;
                        head  <= '0;
                        skid  <= '0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage_control.sv
// Self-checking bench: two stages (CSR on/off) under identical stimulus,
// compared every cycle against a queue-based reference model.
module tb_decode_stage_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_control_if bus1 ();
    decode_stage_control_if bus0 ();

    decode_stage_control #(.ENABLE_CSR(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decode_stage_control #(.ENABLE_CSR(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus0.in_valid       = bus1.in_valid;
    assign bus0.in_instruction = bus1.in_instruction;
    assign bus0.in_pc          = bus1.in_pc;
    assign bus0.out_ready      = bus1.out_ready;
    assign bus0.flush          = bus1.flush;
    assign bus0.trap_ack       = bus1.trap_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [2:0]  sel;
        bit          ill;
    } ment_t;

    // Reference model per config (index = ENABLE_CSR): FIFO of up to two
    // entries plus a trap flag.
    ment_t mq [2][2];
    int    mcnt [2];
    bit    mtrap [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] w, input bit csr,
                                    output logic [2:0] s, output bit il);
        s  = 3'd0;
        il = 1'b0;
        if (w[1:0] != 2'b11) il = 1'b1;
        else case (w[6:0])
            7'h03, 7'h13, 7'h67: s = 3'd1;
            7'h23:               s = 3'd2;
            7'h63:               s = 3'd3;
            7'h37, 7'h17:        s = 3'd4;
            7'h6F:               s = 3'd5;
            7'h33, 7'h0F:        s = 3'd0;
            7'h73: if (w[14:12] != 3'd0) begin
                if (csr) s = 3'd6;
                else     il = 1'b1;
            end
            default: il = 1'b1;
        endcase
    endfunction

    function automatic bit m_in_ready(input int c);
        return !mtrap[c] && mcnt[c] < 2;
    endfunction
    function automatic bit m_out_valid(input int c);
        return !mtrap[c] && mcnt[c] > 0 && !mq[c][0].ill;
    endfunction
    function automatic bit m_illegal(input int c);
        return mcnt[c] > 0 && mq[c][0].ill;
    endfunction

    task automatic chk_outs(input int c, input logic ir, input logic ov, input logic il,
                            input logic [31:0] oi, input logic [31:0] op,
                            input logic [2:0] sel, input logic [31:0] tp);
        string p;
        p = (c == 1) ? "csr1" : "csr0";
        chk({p, ".in_ready"},  {31'd0, ir}, {31'd0, m_in_ready(c)});
        chk({p, ".out_valid"}, {31'd0, ov}, {31'd0, m_out_valid(c)});
        chk({p, ".illegal"},   {31'd0, il}, {31'd0, m_illegal(c)});
        if (m_out_valid(c)) begin
            chk({p, ".out_instruction"}, oi, mq[c][0].ins);
            chk({p, ".out_pc"}, op, mq[c][0].pc);
            chk({p, ".immediate_select"}, {29'd0, sel}, {29'd0, mq[c][0].sel});
        end
        if (m_illegal(c)) chk({p, ".trap_pc"}, tp, mq[c][0].pc);
    endtask

    task automatic m_step(input int c, input bit rn, input bit v, input logic [31:0] ins,
                          input logic [31:0] pc, input bit ordy, input bit fl, input bit ack);
        bit acc, con;
        logic [2:0] s;
        bit il;
        if (!rn || fl) begin
            mcnt[c]  = 0;
            mtrap[c] = 1'b0;
        end else if (mtrap[c]) begin
            if (ack) begin
                mcnt[c]  = 0;
                mtrap[c] = 1'b0;
            end
        end else begin
            acc = v && m_in_ready(c);
            con = m_out_valid(c) && ordy;
            if (m_illegal(c)) mtrap[c] = 1'b1;
            if (con) begin
                mq[c][0] = mq[c][1];
                mcnt[c]--;
            end
            if (acc) begin
                ref_dec(ins, c == 1, s, il);
                mq[c][mcnt[c]] = '{ins: ins, pc: pc, sel: s, ill: il};
                mcnt[c]++;
            end
        end
    endtask

    // One clock: drive inputs, check current outputs, advance model, cross edge.
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl = 1'b0, input bit ack = 1'b0,
                       input bit rn = 1'b1);
        rst_n               = rn;
        bus1.in_valid       = v;
        bus1.in_instruction = ins;
        bus1.in_pc          = pc;
        bus1.out_ready      = ordy;
        bus1.flush          = fl;
        bus1.trap_ack       = ack;
        chk_outs(1, bus1.in_ready, bus1.out_valid, bus1.illegal, bus1.out_instruction,
                 bus1.out_pc, bus1.immediate_select, bus1.trap_pc);
        chk_outs(0, bus0.in_ready, bus0.out_valid, bus0.illegal, bus0.out_instruction,
                 bus0.out_pc, bus0.immediate_select, bus0.trap_pc);
        for (int c = 0; c < 2; c++) m_step(c, rn, v, ins, pc, ordy, fl, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready1"},  {31'd0, bus1.in_ready}, 32'd1);
        chk({tag, ".out_valid1"}, {31'd0, bus1.out_valid}, 32'd0);
        chk({tag, ".illegal1"},   {31'd0, bus1.illegal}, 32'd0);
        chk({tag, ".out_ins1"},   bus1.out_instruction, 32'd0);
        chk({tag, ".out_pc1"},    bus1.out_pc, 32'd0);
        chk({tag, ".sel1"},       {29'd0, bus1.immediate_select}, 32'd0);
        chk({tag, ".trap_pc1"},   bus1.trap_pc, 32'd0);
        chk({tag, ".in_ready0"},  {31'd0, bus0.in_ready}, 32'd1);
        chk({tag, ".illegal0"},   {31'd0, bus0.illegal}, 32'd0);
    endtask

    logic [6:0] ops [15] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                             7'h33, 7'h0F, 7'h73, 7'h73, 7'h0B, 7'h7F, 7'h02};

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_instruction = '0; bus1.in_pc = '0;
        bus1.out_ready = 1'b0; bus1.flush = 1'b0; bus1.trap_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin mcnt[c] = 0; mtrap[c] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        // Streaming at full rate.
        cyc(1, 32'h00500093, 32'h0, 1);  chk("addi.sel", {29'd0, bus1.immediate_select}, 32'd1);
        cyc(1, 32'h00112023, 32'h4, 1);  chk("sw.sel",   {29'd0, bus1.immediate_select}, 32'd2);
        cyc(1, 32'hFE000EE3, 32'h8, 1);  chk("beq.sel",  {29'd0, bus1.immediate_select}, 32'd3);
        cyc(1, 32'h000010B7, 32'hC, 1);  chk("lui.sel",  {29'd0, bus1.immediate_select}, 32'd4);
        chk("stream.in_ready", {31'd0, bus1.in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1);

        // Backpressure fills the skid.
        cyc(1, 32'h0000006F, 32'h20, 0);
        cyc(1, 32'h00000033, 32'h24, 0);
        chk("bp.in_ready", {31'd0, bus1.in_ready}, 32'd0);
        chk("bp.jal.sel", {29'd0, bus1.immediate_select}, 32'd5);
        cyc(1, 32'h00000013, 32'h28, 0);
        chk("bp.jal.stable", bus1.out_instruction, 32'h0000006F);
        cyc(0, 32'h0, 32'h0, 1);
        chk("bp.add.next", bus1.out_instruction, 32'h00000033);
        cyc(0, 32'h0, 32'h0, 1);
        chk("bp.drained", {31'd0, bus1.out_valid}, 32'd0);

        // Illegal instruction and trap handshake.
        cyc(1, 32'hFFFFFFFF, 32'h100, 1);
        chk("ill.flag", {31'd0, bus1.illegal}, 32'd1);
        chk("ill.trap_pc", bus1.trap_pc, 32'h100);
        cyc(0, 32'h0, 32'h0, 1);
        chk("trap.in_ready", {31'd0, bus1.in_ready}, 32'd0);
        cyc(1, 32'h00500093, 32'h104, 1);
        cyc(0, 32'h0, 32'h0, 1, 0, 1);
        chk("ack.in_ready", {31'd0, bus1.in_ready}, 32'd1);
        chk("ack.illegal", {31'd0, bus1.illegal}, 32'd0);

        // CSR handling in both configurations.
        cyc(1, 32'h300022F3, 32'h200, 1);
        chk("csr.sel1", {29'd0, bus1.immediate_select}, 32'd6);
        chk("csr.ill0", {31'd0, bus0.illegal}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1);
        cyc(0, 32'h0, 32'h0, 1, 0, 1);
        cyc(1, 32'h00000073, 32'h204, 1);
        chk("ecall.sel1", {29'd0, bus1.immediate_select}, 32'd0);
        chk("ecall.ov0", {31'd0, bus0.out_valid}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1);

        // Flush beats accept and trap_ack.
        cyc(1, 32'h00500093, 32'h300, 0);
        cyc(1, 32'h00112023, 32'h304, 0);
        cyc(1, 32'h0000006F, 32'h308, 0, 1, 1);
        chk("flush.out_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("flush.in_ready", {31'd0, bus1.in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1);

        // Reset with skid full and illegal pending.
        cyc(1, 32'hFFFFFFFF, 32'h400, 0);
        cyc(1, 32'h00500093, 32'h404, 0);
        chk("prerst.illegal", {31'd0, bus1.illegal}, 32'd1);
        cyc(1, 32'h00112023, 32'h408, 1, 0, 1, 0);
        chk_reset_vals("midrst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 14)];
            if ($urandom_range(0, 3) == 0) w[14:12] = 3'd0;
            cyc($urandom_range(0, 9) < 7, w, $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 99) < 3, $urandom_range(0, 4) == 0,
                $urandom_range(0, 99) != 0);
        end
        cyc(0, 32'h0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
